// File: rtl/vram_port_arbiter.sv
// Two-master Wishbone arbiter that shares one 16-bit VRAM port between the CPU (M0) and the blitter (M1).
// Round-robin on contention; a grant is held for the winner's whole CYC, so locked bursts stay indivisible.
module vram_port_arbiter (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        M0_CYC_I,
   input  logic        M0_STB_I,
   input  logic        M0_WE_I,
   input  logic [12:0] M0_ADR_I,
   input  logic [1:0]  M0_SEL_I,
   input  logic [15:0] M0_DAT_I,
   output logic [15:0] M0_DAT_O,
   output logic        M0_ACK_O,
   input  logic        M1_CYC_I,
   input  logic        M1_STB_I,
   input  logic        M1_WE_I,
   input  logic [12:0] M1_ADR_I,
   input  logic [1:0]  M1_SEL_I,
   input  logic [15:0] M1_DAT_I,
   output logic [15:0] M1_DAT_O,
   output logic        M1_ACK_O,
   output logic        S_CYC_O,
   output logic        S_STB_O,
   output logic        S_WE_O,
   output logic [12:0] S_ADR_O,
   output logic [1:0]  S_SEL_O,
   output logic [15:0] S_DAT_O,
   input  logic [15:0] S_DAT_I,
   input  logic        S_ACK_I,
   output logic [1:0]  GNT_O
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] G0   = 2'd1;
   localparam logic [1:0] G1   = 2'd2;

   logic [1:0] st;
   logic [1:0] st_nxt;
   logic       last;
   logic       req0;
   logic       req1;

   assign req0 = M0_CYC_I & M0_STB_I;
   assign req1 = M1_CYC_I & M1_STB_I;

   always_comb begin
      // NOTE: assign a default before the case so every path drives st_nxt and no latch is inferred.
      st_nxt = st;
      case (st)
         IDLE: begin
            if (req0 && req1) st_nxt = last ? G0 : G1;
            else if (req0)    st_nxt = G0;
            else if (req1)    st_nxt = G1;
            else              st_nxt = IDLE;
         end
         G0: begin
            // Owner keeps the port until it drops CYC; the waiter is handed off with no idle gap.
            if (!M0_CYC_I) begin
               if (req1)      st_nxt = G1;
               else if (req0) st_nxt = G0;
               else           st_nxt = IDLE;
            end
         end
         G1: begin
            if (!M1_CYC_I) begin
               if (req0)      st_nxt = G0;
               else if (req1) st_nxt = G1;
               else           st_nxt = IDLE;
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         st   <= IDLE;
         last <= 1'b1;
      end else begin
         st <= st_nxt;
         if (st_nxt == G0)      last <= 1'b0;
         else if (st_nxt == G1) last <= 1'b1;
      end
   end

   always_comb begin
      S_CYC_O = 1'b0;
      S_STB_O = 1'b0;
      S_WE_O  = 1'b0;
      S_ADR_O = '0;
      S_SEL_O = '0;
      S_DAT_O = '0;
      case (st)
         G0: begin
            S_CYC_O = M0_CYC_I;
            S_STB_O = M0_STB_I;
            S_WE_O  = M0_WE_I;
            S_ADR_O = M0_ADR_I;
            S_SEL_O = M0_SEL_I;
            S_DAT_O = M0_DAT_I;
         end
         G1: begin
            S_CYC_O = M1_CYC_I;
            S_STB_O = M1_STB_I;
            S_WE_O  = M1_WE_I;
            S_ADR_O = M1_ADR_I;
            S_SEL_O = M1_SEL_I;
            S_DAT_O = M1_DAT_I;
         end
         default: ;
      endcase
   end

   // An acknowledge arriving while idle (or after a reset) reaches nobody.
   assign M0_ACK_O = S_ACK_I & (st == G0);
   assign M1_ACK_O = S_ACK_I & (st == G1);
   assign M0_DAT_O = S_DAT_I;
   assign M1_DAT_O = S_DAT_I;
   assign GNT_O    = {st == G1, st == G0};

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: grant table vectors, then multi-cycle sequences against a one-wait-state VRAM model
// with a per-master scoreboard of expected read data.
module tb_vram_port_arbiter;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [12:0] m0_adr, m1_adr;
   logic [1:0]  m0_sel, m1_sel;
   logic [15:0] m0_dat, m1_dat;
   logic [15:0] M0_DAT_O, M1_DAT_O;
   logic        M0_ACK_O, M1_ACK_O;
   logic        S_CYC_O, S_STB_O, S_WE_O;
   logic [12:0] S_ADR_O;
   logic [1:0]  S_SEL_O;
   logic [15:0] S_DAT_O;
   logic [15:0] S_DAT_I;
   logic        S_ACK_I;
   logic [1:0]  GNT_O;

   always #5 CLK_I = ~CLK_I;

   vram_port_arbiter dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
      .M0_SEL_I(m0_sel), .M0_DAT_I(m0_dat), .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O),
      .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
      .M1_SEL_I(m1_sel), .M1_DAT_I(m1_dat), .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O),
      .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O), .S_ADR_O(S_ADR_O),
      .S_SEL_O(S_SEL_O), .S_DAT_O(S_DAT_O), .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I),
      .GNT_O(GNT_O)
   );

   // VRAM port model: ACK registered one cycle after STB and toggling under held STB.
   logic [15:0] vram   [0:8191];
   logic [15:0] shadow [0:8191];
   logic        vram_ack = 1'b0;
   logic [15:0] vram_rd  = 16'h0;
   logic        ack_force = 1'b0;

   assign S_ACK_I = vram_ack | ack_force;
   assign S_DAT_I = vram_rd;

   always @(posedge CLK_I) begin
      if (S_CYC_O && S_STB_O && !vram_ack) begin
         vram_ack <= 1'b1;
         vram_rd  <= vram[S_ADR_O];
         if (S_WE_O) begin
            if (S_SEL_O[0]) vram[S_ADR_O][7:0]  <= S_DAT_O[7:0];
            if (S_SEL_O[1]) vram[S_ADR_O][15:8] <= S_DAT_O[15:8];
         end
      end else begin
         vram_ack <= 1'b0;
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   int          other_hits = 0;
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   logic [1:0]  pend_rd = 2'b00;

   typedef struct {
      logic       rst;
      logic       c0, s0, c1, s1;
      logic [1:0] gnt;
   } vec_t;

   vec_t        vecs [15];
   logic [49:0] exp_bus;
   int          lat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int m, input logic we, input logic [12:0] adr,
                        input logic [1:0] sel, input logic [15:0] dat);
      if (m == 0) begin
         m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat = dat;
      end else begin
         m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat = dat;
      end
      if (we) begin
         if (sel[0]) shadow[adr][7:0]  = dat[7:0];
         if (sel[1]) shadow[adr][15:8] = dat[15:8];
      end else if (m == 0) begin
         q0.push_back(shadow[adr]);
      end else begin
         q1.push_back(shadow[adr]);
      end
      pend_rd[m] = !we;
   endtask

   task automatic release_bus(input int m);
      if (m == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      else        begin m1_cyc = 1'b0; m1_stb = 1'b0; end
   endtask

   // Waits (bounded) for master m's ACK; lat_o is the number of falling edges waited.
   task automatic wait_ack(input int m, output int lat_o);
      logic        got;
      logic [15:0] exp_d;
      got   = 1'b0;
      lat_o = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge CLK_I);
         if (m == 0 ? (M1_ACK_O && !m1_cyc) : (M0_ACK_O && !m0_cyc)) other_hits++;
         if ((m == 0 ? M0_ACK_O : M1_ACK_O) === 1'b1) begin
            got   = 1'b1;
            lat_o = i;
            break;
         end
      end
      check($sformatf("m%0d_ack_seen", m), got, 1);
      if (got && pend_rd[m]) begin
         if (m == 0 && q0.size() > 0) begin
            exp_d = q0.pop_front();
            check("m0_rd_data", M0_DAT_O, exp_d);
         end else if (m == 1 && q1.size() > 0) begin
            exp_d = q1.pop_front();
            check("m1_rd_data", M1_DAT_O, exp_d);
         end
         pend_rd[m] = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 8192; a++) begin
         vram[a]   = 16'h0;
         shadow[a] = 16'h0;
      end
      vram[16]   = 16'hBEEF;
      shadow[16] = 16'hBEEF;

      RST_I  = 1'b1;
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b1; m0_adr = 13'h0AA; m0_sel = 2'b01; m0_dat = 16'h1111;
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 13'h155; m1_sel = 2'b10; m1_dat = 16'h2222;
      repeat (2) @(negedge CLK_I);

      // Grant sequence table: rst, c0, s0, c1, s1, grant expected after the edge.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

      for (int i = 0; i < 15; i++) begin
         RST_I  = vecs[i].rst;
         m0_cyc = vecs[i].c0; m0_stb = vecs[i].s0;
         m1_cyc = vecs[i].c1; m1_stb = vecs[i].s1;
         @(negedge CLK_I);
         if (vecs[i].gnt == 2'b01)
            exp_bus = {vecs[i].c0, vecs[i].s0, 1'b1, 13'h0AA, 2'b01, 16'h1111, 15'h0};
         else if (vecs[i].gnt == 2'b10)
            exp_bus = {vecs[i].c1, vecs[i].s1, 1'b0, 13'h155, 2'b10, 16'h2222, 15'h0};
         else
            exp_bus = '0;
         check($sformatf("vec%0d_gnt", i), GNT_O, vecs[i].gnt);
         check($sformatf("vec%0d_bus", i), {S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_SEL_O, S_DAT_O, 15'h0}, exp_bus);
      end

      // Single read after reset: grant next cycle, ACK two cycles after the request.
      RST_I = 1'b0;
      release_bus(0);
      release_bus(1);
      @(negedge CLK_I);
      drive(0, 1'b0, 13'h0010, 2'b11, 16'h0);
      @(negedge CLK_I);
      check("rd_gnt", GNT_O, 2'b01);
      check("rd_s_adr", S_ADR_O, 13'h0010);
      check("rd_ack_early", M0_ACK_O, 0);
      wait_ack(0, lat);
      check("rd_latency", lat, 1);
      release_bus(0);

      // Locked burst: M0 writes four words while M1 waits, then M1 reads them back.
      @(negedge CLK_I);
      drive(0, 1'b1, 13'h0100, 2'b11, 16'hA5A5);
      @(negedge CLK_I);
      check("burst_gnt_start", GNT_O, 2'b01);
      drive(1, 1'b0, 13'h0100, 2'b11, 16'h0);
      for (int i = 0; i < 4; i++) begin
         wait_ack(0, lat);
         check($sformatf("burst_gnt_w%0d", i), GNT_O, 2'b01);
         if (i < 3) drive(0, 1'b1, 13'h0101 + 13'(i), 2'b11, 16'hA5A6 + 16'(i));
         else       release_bus(0);
      end
      @(negedge CLK_I);
      check("handoff_gnt", GNT_O, 2'b10);
      wait_ack(1, lat);
      for (int j = 1; j < 4; j++) begin
         drive(1, 1'b0, 13'h0100 + 13'(j), 2'b11, 16'h0);
         wait_ack(1, lat);
      end
      release_bus(1);

      // Byte write from M1 merges into a word M0 wrote, M0 reads the result.
      @(negedge CLK_I);
      drive(0, 1'b1, 13'h0200, 2'b11, 16'h1234);
      wait_ack(0, lat);
      release_bus(0);
      @(negedge CLK_I);
      drive(1, 1'b1, 13'h0200, 2'b10, 16'h7F00);
      wait_ack(1, lat);
      release_bus(1);
      @(negedge CLK_I);
      drive(0, 1'b0, 13'h0200, 2'b11, 16'h0);
      wait_ack(0, lat);
      check("byte_merge", M0_DAT_O, 16'h7F34);
      release_bus(0);

      // Simultaneous requests from idle: last owner was M0, so M1 wins; M0 follows with no idle gap.
      @(negedge CLK_I);
      drive(0, 1'b0, 13'h0010, 2'b11, 16'h0);
      drive(1, 1'b0, 13'h0101, 2'b11, 16'h0);
      @(negedge CLK_I);
      check("tie1_gnt", GNT_O, 2'b10);
      wait_ack(1, lat);
      release_bus(1);
      @(negedge CLK_I);
      check("tie1_handoff", GNT_O, 2'b01);
      wait_ack(0, lat);
      release_bus(0);

      // Reset while M1 owns the port with STB high.
      @(negedge CLK_I);
      drive(1, 1'b0, 13'h0300, 2'b11, 16'h0);
      @(negedge CLK_I);
      check("rst_pre_gnt", GNT_O, 2'b10);
      check("rst_pre_stb", S_STB_O, 1);
      RST_I = 1'b1;
      @(negedge CLK_I);
      check("rst_cyc", S_CYC_O, 0);
      check("rst_gnt", GNT_O, 2'b00);
      check("rst_acks", {M0_ACK_O, M1_ACK_O}, 2'b00);
      RST_I = 1'b0;
      q1.delete();
      pend_rd[1] = 1'b0;
      drive(0, 1'b0, 13'h0010, 2'b11, 16'h0);
      drive(1, 1'b0, 13'h0300, 2'b11, 16'h0);
      @(negedge CLK_I);
      check("rst_tie_gnt", GNT_O, 2'b01);
      wait_ack(0, lat);
      release_bus(0);
      wait_ack(1, lat);
      release_bus(1);

      // Stray acknowledge while idle reaches neither master.
      @(negedge CLK_I);
      ack_force = 1'b1;
      @(negedge CLK_I);
      check("stray_gnt", GNT_O, 2'b00);
      check("stray_acks", {M0_ACK_O, M1_ACK_O}, 2'b00);
      ack_force = 1'b0;

      check("foreign_ack_hits", other_hits, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
